if_id_stage: RTL and testbench

- Parametrised IF/ID pipeline register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter.
- Sits between the instruction fetch and decode stages.
- Replaces the plain always-load IF/ID latch:
  - fetch may keep issuing while decode stalls, with no combinational ready path from decode back to fetch;
  - branch or jump resolution can squash in-flight fetches.

---
 rtl/if_id_stage.sv | 109 ++++++++++
 tb/tb_if_id_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid buffer
// (main + skid), synchronous flush and a saturating decode-stall counter.
module if_id_stage #(
    parameter int unsigned         INSTR_W   = 32,
    parameter int unsigned         PC_W      = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(32'h0000_0000),
    parameter int unsigned         CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_npc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_npc,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic               out_valid_q,  out_valid_d;
    logic [INSTR_W-1:0] out_instr_q,  out_instr_d;
    logic [PC_W-1:0]    out_npc_q,    out_npc_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_npc_q,   skid_npc_d;
    logic               in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;

    logic accept;
    logic drain;

    // Next-state for the entries; branches mirror the transfer priorities.
    always_comb begin
        accept       = in_valid && in_ready_q;
        drain        = out_valid_q && out_ready;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_npc_d    = out_npc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            out_instr_d  = NOP_INSTR;
            out_npc_d    = '0;
        end else if (skid_valid_q) begin
            if (drain) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_npc_d    = skid_npc_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_valid_d = 1'b1;
                out_instr_d = in_instr;
                out_npc_d   = in_npc;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = in_instr;
                skid_npc_d   = in_npc;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        // Ready is registered so fetch never sees a combinational path from decode.
        in_ready_d = !skid_valid_d;

        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_npc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_npc_q   <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_npc_q    <= out_npc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_npc   = out_npc_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random traffic
// compared against a queue-based reference model of the two-entry stage.
module tb_if_id_stage;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_npc;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_npc;
    logic [CNT_W-1:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of held pairs (at most two) plus last shown pair.
    logic [63:0] mq[$];
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    int unsigned m_cnt;

    if_id_stage #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_npc   (in_npc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_npc  (out_npc),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_instr = NOP;
        m_npc   = 32'd0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                              input logic ordy, input logic fl);
        bit acc;
        bit drn;
        acc = iv && (mq.size() < 2);
        drn = (mq.size() > 0) && ordy;
        if ((mq.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
        if (fl) begin
            mq.delete();
            m_instr = NOP;
            m_npc   = 32'd0;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({ins, pc});
            if (mq.size() > 0) begin
                m_instr = mq[0][63:32];
                m_npc   = mq[0][31:0];
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
        chk({tag, ".out_instr"}, out_instr, m_instr);
        chk({tag, ".out_npc"},   out_npc,   m_npc);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), m_cnt);
    endtask

    // Drive one cycle of inputs away from the edge, step the model at the edge, compare after.
    task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = iv;
        in_instr  = ins;
        in_npc    = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge(iv, ins, pc, ordy, fl);
        #1;
        compare_all(tag);
    endtask

    task automatic reset_between_edges(input string tag);
        rst = 1'b1;
        #2;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".out_instr"}, out_instr, NOP);
        chk({tag, ".out_npc"},   out_npc,   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_npc    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        reset_between_edges("reset");

        // Streaming with decode always ready.
        step("stream0", 1'b1, 32'h2002_0005, 32'd4,  1'b1, 1'b0);
        chk("stream0.instr", out_instr, 32'h2002_0005);
        step("stream1", 1'b1, 32'h2003_0007, 32'd8,  1'b1, 1'b0);
        chk("stream1.instr", out_instr, 32'h2003_0007);
        step("stream2", 1'b1, 32'h0043_2020, 32'd12, 1'b1, 1'b0);
        chk("stream2.instr", out_instr, 32'h0043_2020);
        chk("stream2.cnt", 32'(stall_cnt), 32'd0);
        step("stream3", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

        // Decode stall fills the skid and back-pressures fetch.
        step("stall0", 1'b1, 32'h2002_0005, 32'd4,  1'b1, 1'b0);
        step("stall1", 1'b1, 32'h2003_0007, 32'd8,  1'b0, 1'b0);
        chk("stall1.in_ready", 32'(in_ready), 32'd0);
        step("stall2", 1'b1, 32'h0043_2020, 32'd12, 1'b0, 1'b0);
        step("stall3", 1'b1, 32'h0043_2020, 32'd12, 1'b0, 1'b0);
        chk("stall3.cnt", 32'(stall_cnt), 32'd3);
        chk("stall3.instr", out_instr, 32'h2002_0005);
        step("rel0", 1'b1, 32'h0043_2020, 32'd12, 1'b1, 1'b0);
        chk("rel0.instr", out_instr, 32'h2003_0007);
        chk("rel0.in_ready", 32'(in_ready), 32'd1);
        step("rel1", 1'b1, 32'h0043_2020, 32'd12, 1'b1, 1'b0);
        chk("rel1.instr", out_instr, 32'h0043_2020);
        step("rel2", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
        chk("rel2.valid", 32'(out_valid), 32'd0);
        chk("rel2.hold", out_instr, 32'h0043_2020);

        // Flush with both entries full.
        step("fl0", 1'b1, 32'hAAAA_0001, 32'd100, 1'b0, 1'b0);
        step("fl1", 1'b1, 32'hAAAA_0002, 32'd104, 1'b0, 1'b0);
        step("fl2", 1'b1, 32'hAAAA_0003, 32'd108, 1'b0, 1'b1);
        chk("fl2.instr", out_instr, NOP);
        chk("fl2.in_ready", 32'(in_ready), 32'd1);
        step("fl3", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
        chk("fl3.valid", 32'(out_valid), 32'd0);

        // Flush discards an input accepted while in_ready=1.
        step("fla0", 1'b1, 32'hBBBB_0001, 32'd200, 1'b1, 1'b1);
        chk("fla0.valid", 32'(out_valid), 32'd0);
        step("fla1", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
        chk("fla1.valid", 32'(out_valid), 32'd0);

        // Simultaneous drain and accept with skid empty.
        step("da0", 1'b1, 32'h1111_1111, 32'd16, 1'b1, 1'b0);
        step("da1", 1'b1, 32'h2222_2222, 32'd20, 1'b1, 1'b0);
        chk("da1.instr", out_instr, 32'h2222_2222);
        chk("da1.npc", out_npc, 32'd20);
        chk("da1.in_ready", 32'(in_ready), 32'd1);
        step("da2", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        // Saturation of the stall counter.
        reset_between_edges("rst_sat");
        step("sat0", 1'b1, 32'hCCCC_0001, 32'd300, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b0, 32'h0, 32'd0, 1'b0, 1'b0);
        chk("sat.cnt", 32'(stall_cnt), 32'd15);
        step("sat_hold", 1'b0, 32'h0, 32'd0, 1'b0, 1'b1);
        chk("sat_hold.cnt", 32'(stall_cnt), 32'd15);

        // Asynchronous reset mid-stall.
        step("mid0", 1'b1, 32'hDDDD_0001, 32'd400, 1'b0, 1'b0);
        step("mid1", 1'b1, 32'hDDDD_0002, 32'd404, 1'b0, 1'b0);
        reset_between_edges("rst_mid");
        step("post0", 1'b1, 32'hEEEE_0001, 32'd500, 1'b1, 1'b0);
        step("post1", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
